// File: rtl/vend_ctrl_multi_if.sv
// Front-end / driver bundle for the multi-item vending controller.
// master = keypad, coin acceptor and restock port; slave = the controller itself.
interface vend_ctrl_multi_if #(
   parameter int NUM_ITEMS = 4,
   parameter int CREDIT_W  = 8,
   parameter int STOCK_W   = 4
);
   localparam int ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

   logic                          coin_valid;
   logic [1:0]                    coin_code;
   logic                          sel_valid;
   logic [ITEM_W-1:0]             sel_item;
   logic                          cancel;
   logic [NUM_ITEMS*CREDIT_W-1:0] price;
   logic                          restock_valid;
   logic [ITEM_W-1:0]             restock_item;
   logic [STOCK_W-1:0]            restock_qty;

   logic [CREDIT_W-1:0]           credit;
   logic                          busy;
   logic                          coin_reject;
   logic                          sel_nack;
   logic                          vend_valid;
   logic [ITEM_W-1:0]             vend_item;
   logic                          chg_valid;
   logic [1:0]                    chg_code;

   modport master (
      output coin_valid, coin_code, sel_valid, sel_item, cancel, price,
             restock_valid, restock_item, restock_qty,
      input  credit, busy, coin_reject, sel_nack, vend_valid, vend_item,
             chg_valid, chg_code
   );

   modport slave (
      input  coin_valid, coin_code, sel_valid, sel_item, cancel, price,
             restock_valid, restock_item, restock_qty,
      output credit, busy, coin_reject, sel_nack, vend_valid, vend_item,
             chg_valid, chg_code
   );
endinterface

// File: rtl/vend_ctrl_multi.sv
// Multi-item coin vending controller: credit collection, per-item stock, cancel,
// inactivity refund and serial largest-first change payout. All outputs registered.
module vend_ctrl_multi #(
   parameter int NUM_ITEMS  = 4,
   parameter int CREDIT_W   = 8,
   parameter int MAX_CREDIT = 100,
   parameter int COIN0_VAL  = 5,
   parameter int COIN1_VAL  = 10,
   parameter int COIN2_VAL  = 20,
   parameter int STOCK_W    = 4,
   parameter int TIMEOUT    = 16
) (
   input logic             clk,
   input logic             rst,
   vend_ctrl_multi_if.slave bus
);
   localparam int ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
   localparam int TMR_W  = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_VEND    = 2'd2;
   localparam logic [1:0] S_CHANGE  = 2'd3;

   localparam logic [CREDIT_W-1:0] C0    = CREDIT_W'(COIN0_VAL);
   localparam logic [CREDIT_W-1:0] C1    = CREDIT_W'(COIN1_VAL);
   localparam logic [CREDIT_W-1:0] C2    = CREDIT_W'(COIN2_VAL);
   localparam logic [CREDIT_W:0]   LIMIT = (CREDIT_W + 1)'(MAX_CREDIT);

   logic [1:0]          state, state_d;
   logic [CREDIT_W-1:0] credit_d;
   logic [TMR_W-1:0]    timer, timer_d;
   logic [STOCK_W-1:0]  stock [NUM_ITEMS];
   logic [ITEM_W-1:0]   item_q;
   logic [CREDIT_W-1:0] price_q;

   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_ok;
   logic [CREDIT_W-1:0] sel_price;
   logic                sel_ok;
   logic                sel_in_range;
   logic                restock_in_range;
   logic [1:0]          chg_code_d;
   logic [CREDIT_W-1:0] chg_val;
   logic [CREDIT_W-1:0] chg_rem;

   logic coin_acc, sel_acc, restock_en, pay, vend_do;

   // Item indices only need a range check when NUM_ITEMS is not a power of two.
   if ((1 << ITEM_W) == NUM_ITEMS) begin : g_full_range
      assign sel_in_range     = 1'b1;
      assign restock_in_range = 1'b1;
   end else begin : g_part_range
      assign sel_in_range     = (32'(bus.sel_item) < NUM_ITEMS);
      assign restock_in_range = (32'(bus.restock_item) < NUM_ITEMS);
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      coin_val = C2;
      case (bus.coin_code)
         2'd0:    coin_val = C0;
         2'd1:    coin_val = C1;
         default: coin_val = C2;
      endcase
   end

   // Sum kept one bit wider than credit so an overflowing coin cannot wrap past the limit.
   assign coin_sum  = {1'b0, bus.credit} + {1'b0, coin_val};
   assign coin_ok   = bus.coin_valid && (bus.coin_code != 2'd3) && (coin_sum <= LIMIT);
   assign sel_price = bus.price[bus.sel_item*CREDIT_W +: CREDIT_W];
   assign sel_ok    = sel_in_range && (stock[bus.sel_item] != '0) &&
                      (bus.credit >= sel_price);

   always_comb begin
      chg_code_d = 2'd0;
      chg_val    = C0;
      if (bus.credit >= C2) begin
         chg_code_d = 2'd2;
         chg_val    = C2;
      end else if (bus.credit >= C1) begin
         chg_code_d = 2'd1;
         chg_val    = C1;
      end
   end

   assign chg_rem = (bus.credit > chg_val) ? (bus.credit - chg_val) : '0;

   always_comb begin
      state_d    = state;
      credit_d   = bus.credit;
      timer_d    = '0;
      coin_acc   = 1'b0;
      sel_acc    = 1'b0;
      restock_en = 1'b0;
      pay        = 1'b0;
      vend_do    = 1'b0;
      case (state)
         S_IDLE: begin
            restock_en = bus.restock_valid && restock_in_range;
            if (coin_ok) begin
               coin_acc = 1'b1;
               credit_d = coin_val;
               state_d  = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (bus.cancel) begin
               state_d = S_CHANGE;
            end else if (bus.sel_valid && sel_ok) begin
               sel_acc = 1'b1;
               state_d = S_VEND;
            end else if (coin_ok) begin
               coin_acc = 1'b1;
               credit_d = coin_sum[CREDIT_W-1:0];
            end
            // Any front-end activity restarts the inactivity window.
            if (!(bus.coin_valid || bus.sel_valid || bus.cancel)) begin
               if (timer == TMR_W'(TIMEOUT - 1)) state_d = S_CHANGE;
               else                              timer_d = timer + 1'b1;
            end
         end
         S_VEND: begin
            vend_do  = 1'b1;
            credit_d = (bus.credit > price_q) ? (bus.credit - price_q) : '0;
            state_d  = (credit_d != '0) ? S_CHANGE : S_IDLE;
         end
         S_CHANGE: begin
            if (bus.credit == '0) begin
               state_d = S_IDLE;
            end else begin
               pay      = 1'b1;
               credit_d = chg_rem;
               if (chg_rem == '0) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state and outputs update with non-blocking assignments so every reader sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         timer           <= '0;
         item_q          <= '0;
         price_q         <= '0;
         bus.credit      <= '0;
         bus.busy        <= 1'b0;
         bus.coin_reject <= 1'b0;
         bus.sel_nack    <= 1'b0;
         bus.vend_valid  <= 1'b0;
         bus.vend_item   <= '0;
         bus.chg_valid   <= 1'b0;
         bus.chg_code    <= 2'd0;
         // NOTE: the stock array is a handful of flops, not a RAM, so it is cleared on reset like any state.
         for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= '0;
      end else begin
         state           <= state_d;
         timer           <= timer_d;
         bus.credit      <= credit_d;
         bus.busy        <= (state_d == S_VEND) || (state_d == S_CHANGE);
         bus.coin_reject <= bus.coin_valid && !coin_acc;
         bus.sel_nack    <= bus.sel_valid && !sel_acc;
         bus.vend_valid  <= vend_do;
         bus.chg_valid   <= pay;
         if (vend_do) bus.vend_item <= item_q;
         if (pay)     bus.chg_code  <= chg_code_d;
         if (sel_acc) begin
            item_q  <= bus.sel_item;
            price_q <= sel_price;
         end
         if (restock_en)   stock[bus.restock_item] <= bus.restock_qty;
         else if (vend_do) stock[item_q]           <= stock[item_q] - 1'b1;
      end
   end
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi: expected output events are queued by the
// stimulus and consumed by an independent monitor on the falling clock edge.
module tb_vend_ctrl_multi;
   localparam int NUM_ITEMS = 4;
   localparam int CREDIT_W  = 8;
   localparam int STOCK_W   = 4;

   typedef enum int {EV_REJ = 0, EV_NACK = 1, EV_VEND = 2, EV_CHG = 3} ev_e;
   typedef struct {
      ev_e kind;
      int  data;
      int  credit;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   vend_ctrl_multi_if #(.NUM_ITEMS(NUM_ITEMS), .CREDIT_W(CREDIT_W), .STOCK_W(STOCK_W)) bus ();

   vend_ctrl_multi #(
      .NUM_ITEMS(NUM_ITEMS), .CREDIT_W(CREDIT_W), .MAX_CREDIT(100),
      .COIN0_VAL(5), .COIN1_VAL(10), .COIN2_VAL(20),
      .STOCK_W(STOCK_W), .TIMEOUT(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input ev_e k, input int d, input int c);
      exp_t e;
      e.kind   = k;
      e.data   = d;
      e.credit = c;
      sb.push_back(e);
   endtask

   task automatic observe(input ev_e k, input int d);
      exp_t e;
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_event: got kind %0d data %0d, expected no event", k, d);
      end else begin
         e = sb.pop_front();
         check("ev_kind", k, e.kind);
         check("ev_data", d, e.data);
         check("ev_credit", bus.credit, e.credit);
      end
   endtask

   // Monitor: fixed per-cycle order reject, nack, vend, change.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.coin_reject) observe(EV_REJ, 0);
         if (bus.sel_nack)    observe(EV_NACK, 0);
         if (bus.vend_valid)  observe(EV_VEND, int'(bus.vend_item));
         if (bus.chg_valid)   observe(EV_CHG, int'(bus.chg_code));
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input logic [1:0] code);
      bus.coin_valid = 1'b1;
      bus.coin_code  = code;
      cycle();
      bus.coin_valid = 1'b0;
   endtask

   task automatic select(input logic [1:0] item);
      bus.sel_valid = 1'b1;
      bus.sel_item  = item;
      cycle();
      bus.sel_valid = 1'b0;
   endtask

   task automatic do_cancel();
      bus.cancel = 1'b1;
      cycle();
      bus.cancel = 1'b0;
   endtask

   task automatic restock(input logic [1:0] item, input logic [3:0] qty);
      bus.restock_valid = 1'b1;
      bus.restock_item  = item;
      bus.restock_qty   = qty;
      cycle();
      bus.restock_valid = 1'b0;
   endtask

   task automatic set_price(input int item, input int value);
      bus.price[item*CREDIT_W +: CREDIT_W] = CREDIT_W'(value);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 64) begin
         cycle();
         n++;
      end
      check("idle_reached", bus.busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100000 ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.coin_valid = 1'b0; bus.coin_code = 2'd0;
      bus.sel_valid = 1'b0;  bus.sel_item = '0;
      bus.cancel = 1'b0;     bus.price = '0;
      bus.restock_valid = 1'b0; bus.restock_item = '0; bus.restock_qty = '0;
      rst = 1'b1;
      repeat (2) cycle();

      check("rst_credit", bus.credit, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_vend_valid", bus.vend_valid, 0);
      check("rst_vend_item", bus.vend_item, 0);
      check("rst_chg_valid", bus.chg_valid, 0);
      check("rst_chg_code", bus.chg_code, 0);
      check("rst_coin_reject", bus.coin_reject, 0);
      check("rst_sel_nack", bus.sel_nack, 0);
      rst = 1'b0;

      set_price(0, 0); set_price(1, 60); set_price(2, 15); set_price(3, 30);

      // Invalid coin code in IDLE, and selection in IDLE.
      push(EV_REJ, 0, 0);
      coin(2'd3);
      check("idle_bad_coin_busy", bus.busy, 0);
      push(EV_NACK, 0, 0);
      select(2'd2);
      check("idle_sel_credit", bus.credit, 0);

      // Basic purchase with one change coin.
      restock(2'd2, 4'd3);
      coin(2'd1);
      check("t1_credit_10", bus.credit, 10);
      coin(2'd1);
      check("t1_credit_20", bus.credit, 20);
      push(EV_VEND, 2, 5);
      push(EV_CHG, 0, 0);
      select(2'd2);
      check("t1_vend_busy", bus.busy, 1);
      wait_idle();
      check("t1_credit_end", bus.credit, 0);

      // Credit ceiling, then refund with a coin and a selection during payout.
      coin(2'd2); coin(2'd2); coin(2'd2); coin(2'd2); coin(2'd1); coin(2'd0);
      check("t2_credit_95", bus.credit, 95);
      push(EV_REJ, 0, 95);
      coin(2'd1);
      check("t2_credit_hold", bus.credit, 95);
      push(EV_REJ, 0, 75);
      push(EV_NACK, 0, 75);
      push(EV_CHG, 2, 75);
      push(EV_CHG, 2, 55);
      push(EV_CHG, 2, 35);
      push(EV_CHG, 2, 15);
      push(EV_CHG, 1, 5);
      push(EV_CHG, 0, 0);
      do_cancel();
      bus.coin_valid = 1'b1; bus.coin_code = 2'd0;
      bus.sel_valid = 1'b1;  bus.sel_item = 2'd2;
      cycle();
      bus.coin_valid = 1'b0; bus.sel_valid = 1'b0;
      wait_idle();
      check("t2_credit_end", bus.credit, 0);

      // Refused selections: empty item, restock ignored in COLLECT, price too high.
      coin(2'd2); coin(2'd2); coin(2'd1);
      push(EV_NACK, 0, 50);
      select(2'd1);
      check("t3_busy", bus.busy, 0);
      check("t3_credit", bus.credit, 50);
      restock(2'd3, 4'd5);
      push(EV_NACK, 0, 50);
      select(2'd3);
      push(EV_CHG, 2, 30); push(EV_CHG, 2, 10); push(EV_CHG, 1, 0);
      do_cancel();
      wait_idle();
      restock(2'd1, 4'd1);
      coin(2'd2); coin(2'd2); coin(2'd1);
      push(EV_NACK, 0, 50);
      select(2'd1);
      push(EV_CHG, 2, 30); push(EV_CHG, 2, 10); push(EV_CHG, 1, 0);
      do_cancel();
      wait_idle();

      // Inactivity timeout, and a late coin restarting the window.
      coin(2'd0);
      repeat (15) cycle();
      check("t4_pre_timeout_busy", bus.busy, 0);
      check("t4_pre_timeout_credit", bus.credit, 5);
      push(EV_CHG, 0, 0);
      cycle();
      check("t4_timeout_busy", bus.busy, 1);
      wait_idle();
      check("t4_credit_end", bus.credit, 0);
      coin(2'd0);
      repeat (14) cycle();
      coin(2'd0);
      check("t4_late_coin_credit", bus.credit, 10);
      repeat (15) cycle();
      check("t4_no_refund_busy", bus.busy, 0);
      check("t4_no_refund_credit", bus.credit, 10);
      push(EV_CHG, 1, 0);
      do_cancel();
      wait_idle();

      // Coin colliding with cancel, then with an accepted selection.
      coin(2'd1);
      push(EV_REJ, 0, 10);
      push(EV_CHG, 1, 0);
      bus.cancel = 1'b1; bus.coin_valid = 1'b1; bus.coin_code = 2'd0;
      cycle();
      bus.cancel = 1'b0; bus.coin_valid = 1'b0;
      wait_idle();
      check("t5_cancel_credit", bus.credit, 0);
      coin(2'd2);
      push(EV_REJ, 0, 20);
      push(EV_VEND, 2, 5);
      push(EV_CHG, 0, 0);
      bus.sel_valid = 1'b1; bus.sel_item = 2'd2; bus.coin_valid = 1'b1; bus.coin_code = 2'd0;
      cycle();
      bus.sel_valid = 1'b0; bus.coin_valid = 1'b0;
      wait_idle();

      // Third vend empties item 2; the next request must be refused.
      coin(2'd2);
      push(EV_VEND, 2, 5);
      push(EV_CHG, 0, 0);
      select(2'd2);
      wait_idle();
      coin(2'd2);
      push(EV_NACK, 0, 20);
      select(2'd2);
      push(EV_CHG, 2, 0);
      do_cancel();
      wait_idle();

      // Free item: vend leaves credit untouched, which is then refunded.
      restock(2'd0, 4'd2);
      coin(2'd0);
      push(EV_VEND, 0, 5);
      push(EV_CHG, 0, 0);
      select(2'd0);
      wait_idle();
      check("t_free_credit", bus.credit, 0);

      // Reset in the middle of a refund drops credit and all stock.
      coin(2'd2); coin(2'd1);
      do_cancel();
      check("t6_change_busy", bus.busy, 1);
      check("t6_change_credit", bus.credit, 30);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("t6_rst_credit", bus.credit, 0);
      check("t6_rst_chg_valid", bus.chg_valid, 0);
      check("t6_rst_busy", bus.busy, 0);
      coin(2'd0);
      push(EV_NACK, 0, 5);
      select(2'd0);
      push(EV_CHG, 0, 0);
      do_cancel();
      wait_idle();

      repeat (2) cycle();
      check("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
